sync_width_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ram.sv | 54 +++++
 rtl/sync_width_fifo.sv | 120 ++++++++++++
 tb/tb_sync_width_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Width, ratio and depth helpers shared by the asymmetric-width FIFO and its storage.
package fifo_pkg;

  localparam int FWFT_STD = 0;
  localparam int FWFT_ON  = 1;

  function automatic int unit_width(int wr_w, int rd_w);
    return (wr_w < rd_w) ? wr_w : rd_w;
  endfunction

  function automatic int ratio(int w, int unit_w);
    return w / unit_w;
  endfunction

  function automatic int read_depth(int wr_depth, int wr_w, int rd_w);
    return (wr_depth * wr_w) / rd_w;
  endfunction

  function automatic int count_width(int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Unit-wide storage: one write port of WR_UNITS units, one read port of RD_UNITS units.
// Read is registered (1 cycle, reset to zero) or combinational in fall-through mode; no backpressure.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int UNIT_W   = 4,
  parameter int DEPTH    = 16,
  parameter int WR_UNITS = 2,
  parameter int RD_UNITS = 1,
  parameter int FWFT     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [$clog2(DEPTH)-1:0]     waddr,
  input  logic [WR_UNITS*UNIT_W-1:0]   wdata,
  input  logic                         re,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  output logic [RD_UNITS*UNIT_W-1:0]   rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [UNIT_W-1:0]          mem [DEPTH];
  logic [RD_UNITS*UNIT_W-1:0] rd_word;

  // Most significant slice of a write word occupies the lowest address.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WR_UNITS; i++) begin
        mem[waddr + AW'(i)] <= wdata[(WR_UNITS-1-i)*UNIT_W +: UNIT_W];
      end
    end
  end

  for (genvar g = 0; g < RD_UNITS; g++) begin : g_rd
    assign rd_word[(RD_UNITS-1-g)*UNIT_W +: UNIT_W] = mem[raddr + AW'(g)];
  end

  if (FWFT == FWFT_ON) begin : g_comb_rd
    assign rdata = rd_word;
  end else begin : g_reg_rd
    logic [RD_UNITS*UNIT_W-1:0] rdata_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (re) begin
        rdata_q <= rd_word;
      end
    end
    assign rdata = rdata_q;
  end

endmodule

// File: rtl/sync_width_fifo.sv
// Single-clock FIFO with differing write/read widths; occupancy kept in min-width units.
// Standard read returns data 1 cycle after rd_en, FWFT shows head combinationally; full/empty reject with overflow/underflow pulses.
module sync_width_fifo
  import fifo_pkg::*;
#(
  parameter int WRITE_WIDTH = 8,
  parameter int READ_WIDTH  = 4,
  parameter int WRITE_DEPTH = 8,
  parameter int ALMOST_WR   = 2,
  parameter int ALMOST_RD   = 1,
  parameter int FWFT        = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [WRITE_WIDTH-1:0]         din,
  input  logic                           rd_en,
  output logic [READ_WIDTH-1:0]          dout,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic                           wr_ack,
  output logic                           valid,
  output logic                           overflow,
  output logic                           underflow,
  output logic [count_width(WRITE_DEPTH)-1:0] wr_count,
  output logic [count_width(read_depth(WRITE_DEPTH, WRITE_WIDTH, READ_WIDTH))-1:0] rd_count
);

  localparam int UNIT_W   = unit_width(WRITE_WIDTH, READ_WIDTH);
  localparam int WR_UNITS = ratio(WRITE_WIDTH, UNIT_W);
  localparam int RD_UNITS = ratio(READ_WIDTH, UNIT_W);
  localparam int UNITS    = WRITE_DEPTH * WR_UNITS;
  localparam int AW       = $clog2(UNITS);
  localparam int OW       = AW + 1;
  localparam int WCW      = count_width(WRITE_DEPTH);
  localparam int RCW      = count_width(read_depth(WRITE_DEPTH, WRITE_WIDTH, READ_WIDTH));

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          wr_ack_q, overflow_q, underflow_q, valid_q;
  logic          wr_acc, rd_acc;
  logic [READ_WIDTH-1:0] ram_rdata;

  assign full   = occ_q > OW'(UNITS - WR_UNITS);
  assign empty  = occ_q < OW'(RD_UNITS);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // A partially drained write word still counts as occupying a write slot.
  assign wr_count     = WCW'((occ_q + OW'(WR_UNITS - 1)) / OW'(WR_UNITS));
  assign rd_count     = RCW'(occ_q / OW'(RD_UNITS));
  assign almost_full  = wr_count >= WCW'(WRITE_DEPTH - ALMOST_WR);
  assign almost_empty = rd_count <= RCW'(ALMOST_RD);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(WR_UNITS);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(RD_UNITS);
    end
    occ_d = occ_q + (wr_acc ? OW'(WR_UNITS) : '0) - (rd_acc ? OW'(RD_UNITS) : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
      valid_q     <= rd_acc;
    end
  end

  fifo_ram #(
    .UNIT_W   (UNIT_W),
    .DEPTH    (UNITS),
    .WR_UNITS (WR_UNITS),
    .RD_UNITS (RD_UNITS),
    .FWFT     (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Fall-through output is forced to zero while empty so reset and idle show a clean bus.
  if (FWFT == FWFT_ON) begin : g_fwft
    assign dout  = empty ? '0 : ram_rdata;
    assign valid = !empty;
  end else begin : g_std
    assign dout  = ram_rdata;
    assign valid = valid_q;
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_width_fifo.sv
// Directed checks of sync_width_fifo in 8->4, 4->8, 8->8 and 8->4 fall-through configurations.
module tb_sync_width_fifo;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: 8->4, depth 8, standard read
  logic       wr_en0, rd_en0, full0, empty0, af0, ae0, ack0, val0, ovf0, udf0;
  logic [7:0] din0;
  logic [3:0] dout0, wc0;
  logic [4:0] rc0;
  // u1: 4->8, depth 8, standard read
  logic       wr_en1, rd_en1, full1, empty1, af1, ae1, ack1, val1, ovf1, udf1;
  logic [3:0] din1, wc1;
  logic [7:0] dout1;
  logic [2:0] rc1;
  // u2: 8->4, depth 8, fall-through
  logic       wr_en2, rd_en2, full2, empty2, af2, ae2, ack2, val2, ovf2, udf2;
  logic [7:0] din2;
  logic [3:0] dout2, wc2;
  logic [4:0] rc2;
  // u3: 8->8, depth 8, standard read
  logic       wr_en3, rd_en3, full3, empty3, af3, ae3, ack3, val3, ovf3, udf3;
  logic [7:0] din3, dout3;
  logic [3:0] wc3, rc3;

  logic [3:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q3[$];

  sync_width_fifo #(.WRITE_WIDTH(8), .READ_WIDTH(4), .WRITE_DEPTH(8), .ALMOST_WR(2), .ALMOST_RD(1), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .din(din0), .rd_en(rd_en0), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .wr_ack(ack0),
    .valid(val0), .overflow(ovf0), .underflow(udf0), .wr_count(wc0), .rd_count(rc0));

  sync_width_fifo #(.WRITE_WIDTH(4), .READ_WIDTH(8), .WRITE_DEPTH(8), .ALMOST_WR(2), .ALMOST_RD(1), .FWFT(0)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .din(din1), .rd_en(rd_en1), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .wr_ack(ack1),
    .valid(val1), .overflow(ovf1), .underflow(udf1), .wr_count(wc1), .rd_count(rc1));

  sync_width_fifo #(.WRITE_WIDTH(8), .READ_WIDTH(4), .WRITE_DEPTH(8), .ALMOST_WR(2), .ALMOST_RD(1), .FWFT(1)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .din(din2), .rd_en(rd_en2), .dout(dout2),
    .full(full2), .empty(empty2), .almost_full(af2), .almost_empty(ae2), .wr_ack(ack2),
    .valid(val2), .overflow(ovf2), .underflow(udf2), .wr_count(wc2), .rd_count(rc2));

  sync_width_fifo #(.WRITE_WIDTH(8), .READ_WIDTH(8), .WRITE_DEPTH(8), .ALMOST_WR(2), .ALMOST_RD(1), .FWFT(0)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .din(din3), .rd_en(rd_en3), .dout(dout3),
    .full(full3), .empty(empty3), .almost_full(af3), .almost_empty(ae3), .wr_ack(ack3),
    .valid(val3), .overflow(ovf3), .underflow(udf3), .wr_count(wc3), .rd_count(rc3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every valid word must match the head of its expected queue.
  always @(negedge clk) begin
    if (val0) begin
      if (q0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u0_spurious_valid: got dout %0h, expected no word", dout0);
      end else chk("u0_dout", 32'(dout0), 32'(q0.pop_front()));
    end
    if (val1) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u1_spurious_valid: got dout %0h, expected no word", dout1);
      end else chk("u1_dout", 32'(dout1), 32'(q1.pop_front()));
    end
    if (val3) begin
      if (q3.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u3_spurious_valid: got dout %0h, expected no word", dout3);
      end else chk("u3_dout", 32'(dout3), 32'(q3.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wr_en0 = 0; rd_en0 = 0; din0 = '0;
    wr_en1 = 0; rd_en1 = 0; din1 = '0;
    wr_en2 = 0; rd_en2 = 0; din2 = '0;
    wr_en3 = 0; rd_en3 = 0; din3 = '0;
    tick(); tick();

    // reset state
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_aempty", 32'(ae0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_afull", 32'(af0), 0);
    chk("rst_wc", 32'(wc0), 0);
    chk("rst_rc", 32'(rc0), 0);
    chk("rst_dout", 32'(dout0), 0);
    chk("rst_valid", 32'(val0), 0);
    chk("rst_ack", 32'(ack0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    chk("rst_udf", 32'(udf0), 0);
    chk("rst_fwft_dout", 32'(dout2), 0);
    chk("rst_fwft_valid", 32'(val2), 0);
    rst = 1'b0;
    tick();

    // wide-to-narrow ordering: 5F, 06 -> 5, F, 0, 6
    wr_en0 = 1; din0 = 8'h5F; tick();
    chk("t31_ack", 32'(ack0), 1);
    chk("t31_rc1", 32'(rc0), 2);
    chk("t31_empty1", 32'(empty0), 0);
    din0 = 8'h06; tick(); wr_en0 = 0;
    chk("t31_wc2", 32'(wc0), 2);
    chk("t31_rc2", 32'(rc0), 4);
    chk("t31_ae", 32'(ae0), 0);
    q0.push_back(4'h5); q0.push_back(4'hF); q0.push_back(4'h0); q0.push_back(4'h6);
    rd_en0 = 1;
    for (int i = 0; i < 4; i++) tick();
    rd_en0 = 0;
    chk("t31_empty_after", 32'(empty0), 1);
    chk("t31_ae_after", 32'(ae0), 1);
    tick();

    // fill to full, overflow, drain with underflow
    wr_en0 = 1;
    for (int i = 0; i < 8; i++) begin
      din0 = 8'h10 + 8'(i);
      tick();
      chk("t33_afull", 32'(af0), 32'(i >= 5));
    end
    chk("t33_full", 32'(full0), 1);
    chk("t33_wc8", 32'(wc0), 8);
    din0 = 8'h18; tick(); wr_en0 = 0;
    chk("t33_ack_rej", 32'(ack0), 0);
    chk("t33_ovf", 32'(ovf0), 1);
    chk("t33_wc_hold", 32'(wc0), 8);
    tick();
    chk("t33_ovf_pulse", 32'(ovf0), 0);
    rd_en0 = 1;
    for (int k = 0; k < 16; k++) begin
      q0.push_back((k % 2 == 0) ? 4'h1 : 4'(k / 2));
      tick();
    end
    tick(); rd_en0 = 0;
    chk("t33_udf", 32'(udf0), 1);
    chk("t33_udf_valid", 32'(val0), 0);
    chk("t33_udf_dout", 32'(dout0), 32'h7);
    tick();
    chk("t33_udf_pulse", 32'(udf0), 0);

    // narrow-to-wide: A then 3 -> A3
    wr_en1 = 1; din1 = 4'hA; tick(); wr_en1 = 0;
    chk("t32_empty_half", 32'(empty1), 1);
    chk("t32_rc0", 32'(rc1), 0);
    chk("t32_wc1", 32'(wc1), 1);
    wr_en1 = 1; din1 = 4'h3; tick(); wr_en1 = 0;
    chk("t32_empty_full", 32'(empty1), 0);
    chk("t32_rc1", 32'(rc1), 1);
    q1.push_back(8'hA3);
    rd_en1 = 1; tick(); rd_en1 = 0;
    chk("t32_empty_after", 32'(empty1), 1);
    tick();

    // streaming with equal widths: occupancy held at 4 words across pointer wrap
    wr_en3 = 1;
    for (int i = 0; i < 4; i++) begin
      din3 = 8'h40 + 8'(i);
      tick();
    end
    rd_en3 = 1;
    for (int i = 0; i < 16; i++) begin
      din3 = 8'h44 + 8'(i);
      q3.push_back(8'h40 + 8'(i));
      tick();
      chk("t34_wc", 32'(wc3), 4);
    end
    wr_en3 = 0;
    for (int i = 16; i < 20; i++) begin
      q3.push_back(8'h40 + 8'(i));
      tick();
    end
    rd_en3 = 0;
    chk("t34_empty", 32'(empty3), 1);
    tick();

    // fall-through: head visible without rd_en
    wr_en2 = 1; din2 = 8'hC3; tick(); wr_en2 = 0;
    chk("t35_dout_c", 32'(dout2), 32'hC);
    chk("t35_valid", 32'(val2), 1);
    tick();
    chk("t35_dout_hold", 32'(dout2), 32'hC);
    rd_en2 = 1; tick(); rd_en2 = 0;
    chk("t35_dout_3", 32'(dout2), 32'h3);
    chk("t35_valid2", 32'(val2), 1);
    rd_en2 = 1; tick(); rd_en2 = 0;
    chk("t35_valid_off", 32'(val2), 0);
    chk("t35_empty", 32'(empty2), 1);

    // reset mid-burst at 5 words
    wr_en0 = 1;
    for (int i = 0; i < 5; i++) begin
      din0 = 8'h60 + 8'(i);
      tick();
    end
    chk("t36_pre_wc", 32'(wc0), 5);
    din0 = 8'h65;
    rst = 1'b1;
    #1;
    chk("t36_ack", 32'(ack0), 0);
    chk("t36_dout", 32'(dout0), 0);
    chk("t36_wc", 32'(wc0), 0);
    chk("t36_rc", 32'(rc0), 0);
    chk("t36_empty", 32'(empty0), 1);
    chk("t36_ae", 32'(ae0), 1);
    chk("t36_full", 32'(full0), 0);
    chk("t36_af", 32'(af0), 0);
    chk("t36_valid", 32'(val0), 0);
    chk("t36_ovf", 32'(ovf0), 0);
    chk("t36_udf", 32'(udf0), 0);
    wr_en0 = 0;
    tick();
    rst = 1'b0;
    tick();
    wr_en0 = 1; din0 = 8'h11; tick(); wr_en0 = 0;
    q0.push_back(4'h1); q0.push_back(4'h1);
    rd_en0 = 1; tick(); tick(); rd_en0 = 0;
    chk("t36_empty_after", 32'(empty0), 1);
    tick(); tick();

    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q3_drained", 32'(q3.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
